urng96_taus: RTL and testbench
==============================

URNG96_TAUS -- requirements
Module: urng96_taus

Interface
REQ-001 The block SHALL have parameter SEED1, default 32'h0000_1234, meaning the reset/substitute value of Tausworthe component s1 (must be >1).
REQ-002 The block SHALL have parameter SEED2, default 32'h0000_5678, meaning the reset/substitute value of component s2 (must be >7).
REQ-003 The block SHALL have parameter SEED3, default 32'h0009_ABCD, meaning the reset/substitute value of component s3 (must be >15).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- seed_load  in  1  load seed_in into the generator state
- seed_in  in  96  {s1,s2,s3} seed; s1 in [95:64], s2 in [63:32], s3 in [31:0]
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  consumer (96-bit renormaliser) accepts the word
- out_data  out  96  uniform fixed-point fraction in [0,1); MSB = 2^-1
- out_count  out  16  count of accepted words

Function
REQ-005 Each generator step SHALL update all three 32-bit components (taus88, 32-bit truncation):
- s1' = ((s1 & FFFFFFFE)<<12) ^ (((s1<<13)^s1)>>19)
- s2' = ((s2 & FFFFFFF8)<<4) ^ (((s2<<2)^s2)>>25)
- s3' = ((s3 & FFFFFFF0)<<17) ^ (((s3<<3)^s3)>>11)
- step output = s1'^s2'^s3'.
REQ-006 The FSM SHALL have the states FILL0, FILL1, FILL2 and HOLD, and SHALL perform exactly one step per cycle in the FILL states and none in HOLD.
REQ-007 In the FILL states the step output SHALL be written to out_data as follows: FILL0 -> [95:64], FILL1 -> [63:32], FILL2 -> [31:0].
REQ-008 The state transitions SHALL be FILL0->FILL1->FILL2->HOLD unconditionally.
REQ-009 In HOLD, the FSM SHALL return to FILL0 on out_valid&out_ready and otherwise stay in HOLD.
REQ-010 out_valid SHALL be 1 exactly in HOLD; a word SHALL appear on the 3rd rising edge after reset release or after a handshake, giving a maximum of 1 word per 4 cycles.
REQ-011 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-012 out_data bits not yet rewritten in a FILL state SHALL keep their previous values, and consumers SHALL use out_data only while out_valid=1.
REQ-013 On seed_load=1, in any state, the block SHALL load s1/s2/s3 from seed_in.
REQ-014 On seed_load, any seed field at or below its minimum (s1<=1, s2<=7, s3<=15) SHALL be replaced by SEED1/SEED2/SEED3 respectively.
REQ-015 On seed_load the FSM SHALL go to FILL0 and out_valid SHALL drop on the next edge; a partially built word SHALL be discarded.
REQ-016 If seed_load and out_valid&out_ready occur in the same cycle, the word SHALL count as accepted (out_count increments) and seed_load SHALL still take effect.
REQ-017 out_count SHALL increment by 1 on each handshake, wrap from FFFF to 0000, and not be cleared by seed_load.

Reset
REQ-018 While rst_n=0 the block SHALL hold s1=SEED1, s2=SEED2, s3=SEED3, state=FILL0, out_valid=0, out_data=0 and out_count=0, asynchronously.
REQ-019 Deasserting rst_n mid-word SHALL restart the sequence from the parameter seeds, and the first word after reset SHALL always be identical.

Verification
REQ-020 The bench SHALL cover seed_load with seed_in={32'd2,32'd8,32'd16} and out_ready=1 -> out_valid on 3rd edge, out_data=96'h00202080_02002C80_48088062.
REQ-021 The bench SHALL cover out_ready=0 for 10 cycles after out_valid -> out_data/out_valid unchanged, no steps, then a 1-cycle out_ready -> out_count=1 and next word 4 cycles later.
REQ-022 The bench SHALL cover seed_in=96'h0 with seed_load -> output stream identical to the stream after reset.
REQ-023 The bench SHALL cover seed_load during FILL1 -> partial word discarded, out_valid 3 edges later with the word derived from the new seed.
REQ-024 The bench SHALL cover seed_load coincident with a handshake -> out_count increments and the next word derives from the new seed.
REQ-025 The bench SHALL cover 65536 handshakes -> out_count wraps to 0.
REQ-026 The bench SHALL cover rst_n pulsed low mid-FILL2 -> outputs zero immediately, and the first post-reset word matches the golden C taus88 model.

Source files
------------

// File: rtl/urng96_taus.sv
// urng96_taus: taus88 uniform random generator assembling three 32-bit steps
// into one 96-bit fixed-point fraction, offered through a valid/ready handshake.
module urng96_taus #(
    parameter logic [31:0] SEED1 = 32'h0000_1234,
    parameter logic [31:0] SEED2 = 32'h0000_5678,
    parameter logic [31:0] SEED3 = 32'h0009_ABCD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic [95:0] seed_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_data,
    output logic [15:0] out_count
);

    typedef enum logic [1:0] {
        FILL0,
        FILL1,
        FILL2,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
    logic [31:0] s1_nxt;
    logic [31:0] s2_nxt;
    logic [31:0] s3_nxt;
    logic [31:0] step_out;
    logic [31:0] seed_s1;
    logic [31:0] seed_s2;
    logic [31:0] seed_s3;
    logic        handshake;
    logic        step_en;

    assign out_valid = (state == HOLD);
    assign handshake = out_valid & out_ready;
    // A seed load pre-empts the step so the new seed produces the first word.
    assign step_en   = (state != HOLD) && !seed_load;

    // Seed fields too small to keep a component non-degenerate fall back to parameters.
    assign seed_s1 = (seed_in[95:64] <= 32'd1)  ? SEED1 : seed_in[95:64];
    assign seed_s2 = (seed_in[63:32] <= 32'd7)  ? SEED2 : seed_in[63:32];
    assign seed_s3 = (seed_in[31:0]  <= 32'd15) ? SEED3 : seed_in[31:0];

    // One taus88 step of all three components and the combined output.
    always_comb begin
        s1_nxt   = ((s1 & 32'hFFFF_FFFE) << 12) ^ (((s1 << 13) ^ s1) >> 19);
        s2_nxt   = ((s2 & 32'hFFFF_FFF8) << 4)  ^ (((s2 << 2)  ^ s2) >> 25);
        s3_nxt   = ((s3 & 32'hFFFF_FFF0) << 17) ^ (((s3 << 3)  ^ s3) >> 11);
        step_out = s1_nxt ^ s2_nxt ^ s3_nxt;
    end

    // Next-state logic: fill three slices, then hold until accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL0:   state_nxt = FILL1;
            FILL1:   state_nxt = FILL2;
            FILL2:   state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = FILL0;
            default: state_nxt = FILL0;
        endcase
        if (seed_load) begin
            state_nxt = FILL0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL0;
        end else begin
            state <= state_nxt;
        end
    end

    // Generator components: reseed on load, advance once per FILL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= SEED1;
            s2 <= SEED2;
            s3 <= SEED3;
        end else if (seed_load) begin
            s1 <= seed_s1;
            s2 <= seed_s2;
            s3 <= seed_s3;
        end else if (step_en) begin
            s1 <= s1_nxt;
            s2 <= s2_nxt;
            s3 <= s3_nxt;
        end
    end

    // Output word assembly, MSB slice first; untouched slices keep old bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (step_en) begin
            case (state)
                FILL0:   out_data[95:64] <= step_out;
                FILL1:   out_data[63:32] <= step_out;
                FILL2:   out_data[31:0]  <= step_out;
                default: out_data        <= out_data;
            endcase
        end
    end

    // Accepted-word counter; wraps and survives seed loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (handshake) begin
            out_count <= out_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_urng96_taus.sv
// tb_urng96_taus: scoreboard bench for urng96_taus with a taus88 reference model.
`timescale 1ns/1ps
module tb_urng96_taus;

    localparam logic [31:0] SEED1 = 32'h0000_1234;
    localparam logic [31:0] SEED2 = 32'h0000_5678;
    localparam logic [31:0] SEED3 = 32'h0009_ABCD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        seed_load = 1'b0;
    logic [95:0] seed_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [95:0] out_data;
    logic [15:0] out_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] m1, m2, m3;
    logic [15:0] exp_cnt;
    logic [95:0] sb_q[$];
    logic [95:0] last_word;
    logic [95:0] golden0, golden1;

    urng96_taus #(.SEED1(SEED1), .SEED2(SEED2), .SEED3(SEED3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference taus88 components as in the C generator.
    function automatic logic [31:0] taus1(input logic [31:0] s);
        logic [31:0] a, b;
        a = s & 32'hFFFF_FFFE;
        a = a << 12;
        b = (s << 13) ^ s;
        b = b >> 19;
        return a ^ b;
    endfunction

    function automatic logic [31:0] taus2(input logic [31:0] s);
        logic [31:0] a, b;
        a = s & 32'hFFFF_FFF8;
        a = a << 4;
        b = (s << 2) ^ s;
        b = b >> 25;
        return a ^ b;
    endfunction

    function automatic logic [31:0] taus3(input logic [31:0] s);
        logic [31:0] a, b;
        a = s & 32'hFFFF_FFF0;
        a = a << 17;
        b = (s << 3) ^ s;
        b = b >> 11;
        return a ^ b;
    endfunction

    task automatic model_word(output logic [95:0] w);
        logic [31:0] r [3];
        for (int k = 0; k < 3; k++) begin
            m1 = taus1(m1);
            m2 = taus2(m2);
            m3 = taus3(m3);
            r[k] = m1 ^ m2 ^ m3;
        end
        w = {r[0], r[1], r[2]};
    endtask

    task automatic model_reseed(input logic [95:0] s);
        m1 = (s[95:64] <= 32'd1)  ? SEED1 : s[95:64];
        m2 = (s[63:32] <= 32'd7)  ? SEED2 : s[63:32];
        m3 = (s[31:0]  <= 32'd15) ? SEED3 : s[31:0];
    endtask

    task automatic push_word();
        logic [95:0] w;
        model_word(w);
        sb_q.push_back(w);
    endtask

    // Wait (bounded) for out_valid, check latency and pop/compare the word.
    task automatic wait_word(input string tag);
        int unsigned edges;
        logic [95:0] w;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!out_valid && edges < 8);
        check({tag, "_lat"}, 96'(edges), 96'd3);
        w = (sb_q.size() != 0) ? sb_q.pop_front() : 96'hx;
        check({tag, "_data"}, out_data, w);
        last_word = w;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_cnt++;
        check("count", 96'(out_count), 96'(exp_cnt));
    endtask

    task automatic load_seed(input string tag, input logic [95:0] s, input logic rdy);
        seed_in   = s;
        seed_load = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        model_reseed(s);
        check({tag, "_vdrop"}, 96'(out_valid), 96'd0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 96'(out_valid), 96'd0);
        check("rst_data", out_data, 96'd0);
        check("rst_count", 96'(out_count), 96'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_cnt = '0;
        model_reseed({SEED1, SEED2, SEED3});

        // First word after reset.
        push_word();
        wait_word("w0");
        golden0 = last_word;

        // Stall: word and valid must not move while out_ready is low.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 96'(out_valid), 96'd1);
            check("stall_data", out_data, golden0);
        end
        accept();
        push_word();
        wait_word("w1");
        golden1 = last_word;

        // Seed load coincident with a handshake, out_ready held high.
        exp_cnt++;
        load_seed("ld_hs", {32'd2, 32'd8, 32'd16}, 1'b1);
        check("ld_hs_count", 96'(out_count), 96'(exp_cnt));
        push_word();
        wait_word("w_2_8_16");
        check("w_2_8_16_const", out_data, 96'h00202080_02002C80_48088062);
        accept();

        // Seed load during FILL1 discards the partial word.
        @(posedge clk);
        #1;
        check("fill1_valid", 96'(out_valid), 96'd0);
        load_seed("ld_f1", 96'h12345678_9ABCDEF0_0FEDCBA9, 1'b0);
        push_word();
        wait_word("w_f1");
        accept();

        // All-zero seed falls back to the parameter seeds: same stream as reset.
        load_seed("ld_zero", 96'h0, 1'b0);
        push_word();
        wait_word("w_zero0");
        check("zero_eq_rst0", out_data, golden0);
        accept();
        push_word();
        wait_word("w_zero1");
        check("zero_eq_rst1", out_data, golden1);
        accept();

        // Fields exactly at their minimum are also substituted.
        load_seed("ld_min", {32'd1, 32'd7, 32'd15}, 1'b0);
        push_word();
        wait_word("w_min");
        check("min_eq_rst0", out_data, golden0);
        accept();

        // Reset pulse mid-FILL2.
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", 96'(out_valid), 96'd0);
        check("mrst_data", out_data, 96'd0);
        check("mrst_count", 96'(out_count), 96'd0);
        @(negedge clk) rst_n = 1'b1;
        exp_cnt = '0;
        sb_q.delete();
        model_reseed({SEED1, SEED2, SEED3});
        push_word();
        wait_word("w_mrst");
        check("mrst_eq_rst0", out_data, golden0);

        // 65536 back-to-back handshakes: counter wraps to zero.
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            repeat (4) @(posedge clk);
            model_word(last_word);
            if (i == 65534) begin
                #1;
                check("wrap_ffff", 96'(out_count), 96'h0000_FFFF);
            end
        end
        #1;
        out_ready = 1'b0;
        check("wrap_zero", 96'(out_count), 96'd0);
        check("wrap_valid", 96'(out_valid), 96'd1);
        check("wrap_data", out_data, last_word);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
